// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types and constants used by the fetch stage and its consumers.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Canonical addi x0,x0,0; downstream stages use it as a bubble filler.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } inst_fetched_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: entries are allocated at request time and filled when the
// response returns. Latency: a fill is visible at the head the cycle after it is written.
// Backpressure: the head is held until popped; the caller gates alloc with alloc_cnt.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   flush              drop every entry (redirect); wins over alloc/fill/pop
//   alloc, alloc_pc    claim the tail entry for a request just accepted at alloc_pc
//   fill, fill_instr   write the oldest unfilled entry
//   pop                consume the head (ignored unless head_valid)
//   head_valid, head   head entry is allocated and filled, and its {pc, instr}
//   alloc_cnt          entries allocated (filled or not)
//   pend_cnt           entries allocated but still waiting for their response
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [31:0]     fill_instr,
  input  logic            pop,
  output logic            head_valid,
  output inst_fetched_t   head,
  output logic [CW-1:0]   alloc_cnt,
  output logic [CW-1:0]   pend_cnt
);

  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;

  // DEPTH is a power of two, so the pointers wrap naturally.
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] tail_ptr;

  logic pop_ok;

  assign head_valid = (alloc_cnt != '0) && filled_q[head_ptr];
  assign pop_ok     = pop && head_valid;

  always_comb begin
    head = '0;
    if (head_valid) begin
      head.pc    = pc_q[head_ptr];
      head.instr = instr_q[head_ptr];
    end
  end

  // Payload needs no reset: nothing reaches the output unless its filled bit is set.
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_q[tail_ptr] <= alloc_pc;
    end
    if (fill) begin
      instr_q[fill_ptr] <= fill_instr;
    end
  end

  // Alloc touches the free tail, fill the oldest unfilled entry and pop a filled head,
  // so the three never target the same filled bit in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr  <= '0;
      fill_ptr  <= '0;
      tail_ptr  <= '0;
      filled_q  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
    end else if (flush) begin
      head_ptr  <= '0;
      fill_ptr  <= '0;
      tail_ptr  <= '0;
      filled_q  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
    end else begin
      if (alloc) begin
        filled_q[tail_ptr] <= 1'b0;
        tail_ptr           <= tail_ptr + PW'(1);
      end
      if (fill) begin
        filled_q[fill_ptr] <= 1'b1;
        fill_ptr           <= fill_ptr + PW'(1);
      end
      if (pop_ok) begin
        filled_q[head_ptr] <= 1'b0;
        head_ptr           <= head_ptr + PW'(1);
      end
      alloc_cnt <= alloc_cnt + CW'(alloc) - CW'(pop_ok);
      pend_cnt  <= pend_cnt + CW'(alloc) - CW'(fill);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction fetch: owns the PC, issues word requests and hands {pc, instr} to decode.
// Latency: 2 cycles from request acceptance to inst_valid_out with a 1-cycle memory.
// Backpressure: requests stop once buffered + in-flight + to-be-dropped reaches BUF_DEPTH.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   imem_req_valid/ready/addr         word fetch request (addr = pc, stable while stalled)
//   imem_rsp_valid/data               in-order responses, at least one cycle after acceptance
//   redirect_valid/pc                 branch/jump/trap redirect; pc[1:0] ignored
//   inst_valid_out/ready_in           handshake toward decode
//   inst_fetched_out                  {pc, instr} of the buffer head
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid_out,
  input  logic            inst_ready_in,
  output inst_fetched_t   inst_fetched_out
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   alloc_cnt;
  logic [CW-1:0]   pend_cnt;
  logic [CW:0]     inflight;
  logic            req_fire;
  logic            rsp_fill;
  logic            pop;

  // Stale responses still owed by memory occupy credit just like live entries, so the
  // number of outstanding memory transactions never exceeds BUF_DEPTH.
  assign inflight       = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
  assign imem_req_valid = !rst && !redirect_valid && (inflight < (CW + 1)'(BUF_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_fill = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign pop      = inst_valid_out && inst_ready_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~XLEN'(3);
    end else if (req_fire) begin
      pc <= pc + XLEN'(4);
    end
  end

  // On a redirect every unfilled entry becomes a response to throw away; a response
  // arriving in that same cycle is already one of them (or one already owed), hence -1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      drop_cnt <= CW'({1'b0, drop_cnt} + {1'b0, pend_cnt} - (CW + 1)'(imem_rsp_valid));
    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .alloc      (req_fire),
    .alloc_pc   (pc),
    .fill       (rsp_fill),
    .fill_instr (imem_rsp_data),
    .pop        (pop),
    .head_valid (inst_valid_out),
    .head       (inst_fetched_out),
    .alloc_cnt  (alloc_cnt),
    .pend_cnt   (pend_cnt)
  );

  rsp_without_req_a: assert property (
    @(posedge clk) disable iff (rst)
    imem_rsp_valid |-> ((drop_cnt != '0) || (pend_cnt != '0))
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import riscv_pkg::*;

  logic            clk;
  logic            rst;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid_out;
  logic            inst_ready_in;
  inst_fetched_t   inst_fetched_out;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .inst_valid_out   (inst_valid_out),
    .inst_ready_in    (inst_ready_in),
    .inst_fetched_out (inst_fetched_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t         mq[$];
  logic [31:0]   acc_q[$];
  inst_fetched_t dlv_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cycle;
  int lat;
  int first_acc;
  int first_vld;

  logic          s_req_valid;
  logic [31:0]   s_req_addr;
  logic          s_inst_valid;
  inst_fetched_t s_inst;
  logic          s_acc;
  logic          s_pop;
  logic          s_rsp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // One clock cycle: drive the memory response, sample just before the edge, then book-keep.
  task automatic cyc();
    mreq_t e;
    if (mq.size() != 0 && mq[0].due <= cycle) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_inst_valid = inst_valid_out;
    s_inst       = inst_fetched_out;
    s_acc        = imem_req_valid && imem_req_ready;
    s_pop        = inst_valid_out && inst_ready_in;
    s_rsp        = imem_rsp_valid;
    @(posedge clk);
    @(negedge clk);
    if (s_rsp) mq.delete(0);
    if (s_acc) begin
      e.addr = s_req_addr;
      e.due  = cycle + lat;
      mq.push_back(e);
      acc_q.push_back(s_req_addr);
      if (first_acc < 0) first_acc = cycle;
    end
    if (s_inst_valid && first_vld < 0) first_vld = cycle;
    if (s_pop) dlv_q.push_back(s_inst);
    cycle++;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    inst_ready_in  = 1'b0;
    mq.delete();
    acc_q.delete();
    dlv_q.delete();
    cycle     = 0;
    first_acc = -1;
    first_vld = -1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
    end
    n_cmp++;
    if (inst_valid_out !== 1'b0) begin
      n_bad++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid_out);
    end
    n_cmp++;
    if (inst_fetched_out !== '0) begin
      n_bad++; $display("FAIL reset_inst_data: got %h want 0", inst_fetched_out);
    end
  endtask

  task automatic test_stream_and_stall();
    do_reset();
    lat = 1; imem_req_ready = 1'b1; inst_ready_in = 1'b1;
    for (int i = 0; i < 60 && acc_q.size() < 4; i++) cyc();
    n_cmp++;
    if (acc_q.size() != 4) begin
      n_bad++; $display("FAIL stream_accepts: got %0d want 4", acc_q.size());
    end
    n_cmp++;
    if (first_vld - first_acc != 2) begin
      n_bad++; $display("FAIL first_latency: got %0d want 2", first_vld - first_acc);
    end
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_cmp++;
      if (s_req_addr !== 32'h10) begin
        n_bad++; $display("FAIL stall_addr[%0d]: got %h want 00000010", i, s_req_addr);
      end
    end
    n_cmp++;
    if (s_req_valid !== 1'b1) begin
      n_bad++; $display("FAIL stall_valid_held: got %b want 1", s_req_valid);
    end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 60 && acc_q.size() < 8; i++) cyc();
    imem_req_ready = 1'b0;
    repeat (10) cyc();
    n_cmp++;
    if (acc_q.size() != 8 || dlv_q.size() != 8) begin
      n_bad++; $display("FAIL stream_counts: got %0d req %0d dlv want 8 8", acc_q.size(), dlv_q.size());
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (acc_q[k] !== 32'(4 * k) || dlv_q[k].pc !== 32'(4 * k) ||
          dlv_q[k].instr !== mem_word(32'(4 * k))) begin
        n_bad++;
        $display("FAIL stream_item[%0d]: got addr %h pc %h instr %h want addr/pc %h instr %h",
                 k, acc_q[k], dlv_q[k].pc, dlv_q[k].instr, 32'(4 * k), mem_word(32'(4 * k)));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat = 1; imem_req_ready = 1'b1; inst_ready_in = 1'b0;
    repeat (10) cyc();
    n_cmp++;
    if (acc_q.size() != 2) begin
      n_bad++; $display("FAIL bp_accepts: got %0d want 2", acc_q.size());
    end
    n_cmp++;
    if (s_req_valid !== 1'b0 || s_inst_valid !== 1'b1 || s_inst.pc !== 32'h0) begin
      n_bad++; $display("FAIL bp_full_state: got req %b vld %b pc %h want 0 1 00000000",
                        s_req_valid, s_inst_valid, s_inst.pc);
    end
    inst_ready_in = 1'b1;
    cyc();
    n_cmp++;
    if (s_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_pop_cycle_req: got %b want 0", s_req_valid);
    end
    inst_ready_in = 1'b0;
    cyc();
    n_cmp++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8) begin
      n_bad++; $display("FAIL bp_after_pop_req: got %b @%h want 1 @00000008", s_req_valid, s_req_addr);
    end
    inst_ready_in = 1'b1; imem_req_ready = 1'b0;
    repeat (10) cyc();
    n_cmp++;
    if (dlv_q.size() != 3 || dlv_q[0].pc !== 32'h0 || dlv_q[1].pc !== 32'h4 || dlv_q[2].pc !== 32'h8) begin
      n_bad++; $display("FAIL bp_delivered: got n=%0d %h %h %h want 3 0 4 8",
                        dlv_q.size(), dlv_q[0].pc, dlv_q[1].pc, dlv_q[2].pc);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 3; imem_req_ready = 1'b1; inst_ready_in = 1'b1;
    for (int i = 0; i < 10 && acc_q.size() < 2; i++) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    cyc();
    redirect_valid = 1'b0;
    n_cmp++;
    if (s_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL redir_req_suppressed: got %b want 0", s_req_valid);
    end
    n_cmp++;
    if (dut.drop_cnt !== 2'd2) begin
      n_bad++; $display("FAIL redir_drop_cnt: got %0d want 2", dut.drop_cnt);
    end
    for (int i = 0; i < 40 && acc_q.size() < 4; i++) cyc();
    imem_req_ready = 1'b0;
    repeat (15) cyc();
    n_cmp++;
    if (acc_q[2] !== 32'h100 || acc_q[3] !== 32'h104) begin
      n_bad++; $display("FAIL redir_addrs: got %h %h want 00000100 00000104", acc_q[2], acc_q[3]);
    end
    n_cmp++;
    if (dlv_q.size() != 2 || dlv_q[0].pc !== 32'h100 || dlv_q[1].pc !== 32'h104 ||
        dlv_q[0].instr !== mem_word(32'h100)) begin
      n_bad++; $display("FAIL redir_delivered: got n=%0d pc %h %h instr %h want 2 100 104 %h",
                        dlv_q.size(), dlv_q[0].pc, dlv_q[1].pc, dlv_q[0].instr, mem_word(32'h100));
    end
    n_cmp++;
    if (dut.drop_cnt !== 2'd0) begin
      n_bad++; $display("FAIL redir_drop_drained: got %0d want 0", dut.drop_cnt);
    end
  endtask

  task automatic test_back_to_back_redirect();
    do_reset();
    lat = 2; imem_req_ready = 1'b1; inst_ready_in = 1'b1;
    for (int i = 0; i < 10 && acc_q.size() < 2; i++) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    cyc();
    n_cmp++;
    if (s_rsp !== 1'b1 || dut.drop_cnt !== 2'd1) begin
      n_bad++; $display("FAIL b2b_first_drop: got rsp %b drop %0d want 1 1", s_rsp, dut.drop_cnt);
    end
    redirect_pc = 32'h200;
    cyc();
    redirect_valid = 1'b0;
    n_cmp++;
    if (dut.drop_cnt !== 2'd0) begin
      n_bad++; $display("FAIL b2b_second_drop: got %0d want 0", dut.drop_cnt);
    end
    for (int i = 0; i < 40 && acc_q.size() < 5; i++) cyc();
    imem_req_ready = 1'b0;
    repeat (15) cyc();
    n_cmp++;
    if (acc_q[2] !== 32'h200) begin
      n_bad++; $display("FAIL b2b_first_addr: got %h want 00000200", acc_q[2]);
    end
    n_cmp++;
    if (dlv_q.size() != 3 || dlv_q[0].pc !== 32'h200 || dlv_q[1].pc !== 32'h204 || dlv_q[2].pc !== 32'h208) begin
      n_bad++; $display("FAIL b2b_delivered: got n=%0d %h %h %h want 3 200 204 208",
                        dlv_q.size(), dlv_q[0].pc, dlv_q[1].pc, dlv_q[2].pc);
    end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    lat = 1; imem_req_ready = 1'b1; inst_ready_in = 1'b0;
    repeat (10) cyc();
    n_cmp++;
    if (s_inst_valid !== 1'b1) begin
      n_bad++; $display("FAIL midrst_full_before: got %b want 1", s_inst_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (inst_valid_out !== 1'b0 || inst_fetched_out !== '0 || imem_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_async_clear: got vld %b data %h req %b want 0 0 0",
                        inst_valid_out, inst_fetched_out, imem_req_valid);
    end
    do_reset();
    imem_req_ready = 1'b1; inst_ready_in = 1'b1;
    for (int i = 0; i < 20 && acc_q.size() < 3; i++) cyc();
    imem_req_ready = 1'b0;
    repeat (10) cyc();
    n_cmp++;
    if (acc_q[0] !== 32'h0 || dlv_q.size() != 3 || dlv_q[0].pc !== 32'h0 || dlv_q[2].pc !== 32'h8) begin
      n_bad++; $display("FAIL midrst_refetch: got addr %h n=%0d pc0 %h pc2 %h want 0 3 0 8",
                        acc_q[0], dlv_q.size(), dlv_q[0].pc, dlv_q[2].pc);
    end
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready_in = 1'b0; lat = 1;
    test_reset();
    test_stream_and_stall();
    test_backpressure();
    test_redirect();
    test_back_to_back_redirect();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
